// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program-counter sequencer for the 9-bit-word instruction memory
// Launches on start, advances/branches/halts per consumed instruction, counts executed words.
module fetch_sequencer #(
  parameter int PC_BITS  = 12,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PC_BITS-1:0]  start_addr,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [PC_BITS-1:0]  branch_target,
  output logic [PC_BITS-1:0]  pc,
  output logic                fetch_valid,
  output logic                running,
  output logic                done,
  output logic                overflow,
  output logic [CNT_BITS-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_BITS-1:0]  PC_MAX  = '1;
  localparam logic [PC_BITS-1:0]  PC_ONE  = PC_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_t              state, state_nxt;
  logic [PC_BITS-1:0]  pc_nxt;
  logic [CNT_BITS-1:0] count_nxt;
  logic                overflow_nxt;

  assign running     = (state == RUN);
  assign done        = (state == HALTED);
  assign fetch_valid = running & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_count <= count_nxt;
      overflow    <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    count_nxt    = instr_count;
    overflow_nxt = overflow;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt    = RUN;
          pc_nxt       = start_addr;
          count_nxt    = '0;
          overflow_nxt = 1'b0;
        end
      end
      RUN: begin
        // A stalled word is not consumed, so decode flags are ignored too.
        if (!stall) begin
          if (instr_count != CNT_MAX) begin
            count_nxt = instr_count + CNT_ONE;
          end
          if (halt) begin
            state_nxt = HALTED;
          end else if (branch_taken) begin
            pc_nxt = branch_target;
          end else if (pc == PC_MAX) begin
            pc_nxt       = '0;
            overflow_nxt = 1'b1;
            state_nxt    = HALTED;
          end else begin
            pc_nxt = pc + PC_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] start_addr;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic [11:0] pc;
  logic        fetch_valid;
  logic        running;
  logic        done;
  logic        overflow;
  logic [15:0] instr_count;

  int tests_run;
  int tests_failed;

  fetch_sequencer #(.PC_BITS(12), .CNT_BITS(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .running       (running),
    .done          (done),
    .overflow      (overflow),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; start_addr = '0; branch_target = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [11:0] addr);
    start = 1'b1;
    start_addr = addr;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; start_addr = '0; branch_target = '0;
    #3;
    tests_run++;
    if ({pc, instr_count, running, done, fetch_valid, overflow} !== {12'h000, 16'h0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset: pc=%h cnt=%h run=%b done=%b fv=%b ovf=%b, expected all zero",
               pc, instr_count, running, done, fetch_valid, overflow);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (running !== 1'b0 || pc !== 12'h000) begin
      tests_failed++;
      $display("FAIL idle_hold: run=%b pc=%h, expected run=0 pc=000", running, pc);
    end
  endtask

  task automatic test_sequential();
    reset_dut();
    launch(12'h000);
    tests_run++;
    if (pc !== 12'h000 || running !== 1'b1 || fetch_valid !== 1'b1 || instr_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL launch: pc=%h run=%b fv=%b cnt=%0d, expected pc=000 run=1 fv=1 cnt=0",
               pc, running, fetch_valid, instr_count);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests_run++;
      if (pc !== 12'(i) || instr_count !== 16'(i)) begin
        tests_failed++;
        $display("FAIL seq_step%0d: pc=%h cnt=%0d, expected pc=%h cnt=%0d", i, pc, instr_count, 12'(i), i);
      end
    end
    tests_run++;
    if (running !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_running: run=%b done=%b, expected run=1 done=0", running, done);
    end
  endtask

  task automatic test_branch();
    reset_dut();
    launch(12'h000);
    repeat (3) tick();
    branch_taken = 1'b1;
    branch_target = 12'h100;
    tick();
    branch_taken = 1'b0;
    tests_run++;
    if (pc !== 12'h100 || instr_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL branch: pc=%h cnt=%0d, expected pc=100 cnt=4", pc, instr_count);
    end
    tick();
    tests_run++;
    if (pc !== 12'h101 || instr_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL branch_next: pc=%h cnt=%0d, expected pc=101 cnt=5", pc, instr_count);
    end
  endtask

  task automatic test_stall();
    reset_dut();
    launch(12'h000);
    repeat (2) tick();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 12'h100;
    #1;
    tests_run++;
    if (fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_fv: fv=%b, expected 0", fetch_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (pc !== 12'h002 || instr_count !== 16'd2 || fetch_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: pc=%h cnt=%0d fv=%b, expected pc=002 cnt=2 fv=0",
                 i, pc, instr_count, fetch_valid);
      end
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    #1;
    tests_run++;
    if (fetch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release_fv: fv=%b, expected 1", fetch_valid);
    end
    tick();
    tests_run++;
    if (pc !== 12'h003 || instr_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL stall_release: pc=%h cnt=%0d, expected pc=003 cnt=3", pc, instr_count);
    end
  endtask

  task automatic test_halt_restart();
    reset_dut();
    launch(12'h000);
    repeat (7) tick();
    halt = 1'b1;
    branch_taken = 1'b1;
    branch_target = 12'h100;
    tick();
    halt = 1'b0;
    branch_taken = 1'b0;
    tests_run++;
    if (done !== 1'b1 || running !== 1'b0 || pc !== 12'h007 || instr_count !== 16'd8 || fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt: done=%b run=%b pc=%h cnt=%0d fv=%b, expected done=1 run=0 pc=007 cnt=8 fv=0",
               done, running, pc, instr_count, fetch_valid);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || pc !== 12'h007 || instr_count !== 16'd8) begin
      tests_failed++;
      $display("FAIL halted_hold: done=%b pc=%h cnt=%0d, expected done=1 pc=007 cnt=8", done, pc, instr_count);
    end
    launch(12'h040);
    tests_run++;
    if (pc !== 12'h040 || instr_count !== 16'd0 || running !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart: pc=%h cnt=%0d run=%b done=%b, expected pc=040 cnt=0 run=1 done=0",
               pc, instr_count, running, done);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    launch(12'hFFE);
    tick();
    tests_run++;
    if (pc !== 12'hFFF || overflow !== 1'b0 || instr_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL ovf_last: pc=%h ovf=%b cnt=%0d, expected pc=fff ovf=0 cnt=1", pc, overflow, instr_count);
    end
    tick();
    tests_run++;
    if (pc !== 12'h000 || overflow !== 1'b1 || done !== 1'b1 || instr_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL ovf_wrap: pc=%h ovf=%b done=%b cnt=%0d, expected pc=000 ovf=1 done=1 cnt=2",
               pc, overflow, done, instr_count);
    end
    launch(12'h010);
    tests_run++;
    if (overflow !== 1'b0 || pc !== 12'h010 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_clear: ovf=%b pc=%h run=%b, expected ovf=0 pc=010 run=1", overflow, pc, running);
    end
  endtask

  task automatic test_branch_to_last();
    reset_dut();
    launch(12'h020);
    branch_taken = 1'b1;
    branch_target = 12'hFFF;
    tick();
    branch_taken = 1'b0;
    tests_run++;
    if (pc !== 12'hFFF || overflow !== 1'b0 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_last: pc=%h ovf=%b run=%b, expected pc=fff ovf=0 run=1", pc, overflow, running);
    end
  endtask

  task automatic test_reset_mid_run();
    reset_dut();
    launch(12'h050);
    repeat (4) tick();
    start = 1'b1;
    start_addr = 12'h200;
    tick();
    start = 1'b0;
    tests_run++;
    if (pc !== 12'h055 || running !== 1'b1 || instr_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL start_in_run: pc=%h run=%b cnt=%0d, expected pc=055 run=1 cnt=5", pc, running, instr_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pc, instr_count, running, done, fetch_valid, overflow} !== {12'h000, 16'h0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h cnt=%h run=%b done=%b fv=%b ovf=%b, expected all zero",
               pc, instr_count, running, done, fetch_valid, overflow);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    reset_dut();
    launch(12'h010);
    branch_taken = 1'b1;
    branch_target = 12'h010;
    repeat (65534) tick();
    tests_run++;
    if (instr_count !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL sat_before: cnt=%h, expected fffe", instr_count);
    end
    repeat (3) tick();
    branch_taken = 1'b0;
    tests_run++;
    if (instr_count !== 16'hFFFF || pc !== 12'h010) begin
      tests_failed++;
      $display("FAIL sat_hold: cnt=%h pc=%h, expected cnt=ffff pc=010", instr_count, pc);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt_restart();
    test_overflow();
    test_branch_to_last();
    test_reset_mid_run();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
